amo_unit: RTL and testbench

Atomic memory operation sequencer that sits between the core's execute stage and the data memory port. It performs the memory side of RISC-V A-extension style operations: swap, add, xor, and, or, unsigned min/max, LR and SC. It accepts one request at a time, runs the read–modify–write against memory, and returns the old memory word (or the SC status) to the core. Its modify step uses the same operation semantics as the core ALU's atomic cases.

---
 rtl/amo_unit.sv | 198 +++++++++++++++++++
 tb/tb_amo_unit.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/amo_unit.sv
// Atomic read-modify-write sequencer between the core execute stage and the data memory port.
// Latency: AMO 3 cycles, LR / successful SC 2 cycles, failed SC / error 1 cycle, plus memory wait cycles.
// Backpressure: one request in flight; req_ready only in IDLE, response held until rsp_ready.
module amo_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err
);

    localparam logic [3:0] OP_SWAP = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_MIN  = 4'd5;
    localparam logic [3:0] OP_MAX  = 4'd6;
    localparam logic [3:0] OP_LR   = 4'd7;
    localparam logic [3:0] OP_SC   = 4'd8;

    typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    state_t      state_q, state_d;
    req_t        req_q, req_d;
    logic [31:0] old_q, old_d;
    logic        resv_vld_q, resv_vld_d;
    logic [31:0] resv_addr_q, resv_addr_d;

    logic        mem_req_d, mem_we_d;
    logic [31:0] mem_addr_d, mem_wdata_d;
    logic        rsp_valid_d, rsp_err_d;
    logic [31:0] rsp_data_d;

    logic        req_illegal;
    logic        sc_hit;

    function automatic logic [31:0] amo_f(input logic [3:0] op,
                                          input logic [31:0] old,
                                          input logic [31:0] wd);
        case (op)
            OP_SWAP: amo_f = wd;
            OP_ADD:  amo_f = old + wd;
            OP_XOR:  amo_f = old ^ wd;
            OP_AND:  amo_f = old & wd;
            OP_OR:   amo_f = old | wd;
            OP_MIN:  amo_f = (old < wd) ? old : wd;
            OP_MAX:  amo_f = (old > wd) ? old : wd;
            default: amo_f = wd;
        endcase
    endfunction

    assign req_ready   = (state_q == IDLE);
    assign req_illegal = (req_op > OP_SC) || (req_addr[1:0] != 2'b00);
    assign sc_hit      = resv_vld_q && (resv_addr_q == req_addr);

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        old_d       = old_q;
        resv_vld_d  = resv_vld_q;
        resv_addr_d = resv_addr_q;
        mem_req_d   = mem_req;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        rsp_valid_d = rsp_valid;
        rsp_data_d  = rsp_data;
        rsp_err_d   = rsp_err;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_d = '{op: req_op, addr: req_addr, wdata: req_wdata};
                    if (req_illegal) begin
                        state_d     = RSP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = 32'd0;
                    end else if (req_op == OP_SC) begin
                        // Any SC consumes the reservation, hit or miss.
                        resv_vld_d = 1'b0;
                        if (sc_hit) begin
                            state_d     = WR;
                            mem_req_d   = 1'b1;
                            mem_we_d    = 1'b1;
                            mem_addr_d  = req_addr;
                            mem_wdata_d = req_wdata;
                        end else begin
                            state_d     = RSP;
                            rsp_valid_d = 1'b1;
                            rsp_err_d   = 1'b0;
                            rsp_data_d  = 32'd1;
                        end
                    end else begin
                        state_d     = RD;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = req_addr;
                        mem_wdata_d = 32'd0;
                    end
                end
            end
            RD: begin
                if (mem_ack) begin
                    old_d = mem_rdata;
                    if (req_q.op == OP_LR) begin
                        resv_vld_d  = 1'b1;
                        resv_addr_d = req_q.addr;
                        state_d     = RSP;
                        mem_req_d   = 1'b0;
                        mem_addr_d  = 32'd0;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b0;
                        rsp_data_d  = mem_rdata;
                    end else begin
                        if (resv_vld_q && (resv_addr_q == req_q.addr)) begin
                            resv_vld_d = 1'b0;
                        end
                        state_d     = WR;
                        mem_we_d    = 1'b1;
                        mem_wdata_d = amo_f(req_q.op, mem_rdata, req_q.wdata);
                    end
                end
            end
            WR: begin
                if (mem_ack) begin
                    state_d     = RSP;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = 32'd0;
                    mem_wdata_d = 32'd0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = (req_q.op == OP_SC) ? 32'd0 : old_q;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = 32'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_q       <= '0;
            old_q       <= 32'd0;
            resv_vld_q  <= 1'b0;
            resv_addr_q <= 32'd0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 32'd0;
            mem_wdata   <= 32'd0;
            rsp_valid   <= 1'b0;
            rsp_data    <= 32'd0;
            rsp_err     <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            old_q       <= old_d;
            resv_vld_q  <= resv_vld_d;
            resv_addr_q <= resv_addr_d;
            mem_req     <= mem_req_d;
            mem_we      <= mem_we_d;
            mem_addr    <= mem_addr_d;
            mem_wdata   <= mem_wdata_d;
            rsp_valid   <= rsp_valid_d;
            rsp_data    <= rsp_data_d;
            rsp_err     <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_amo_unit.sv
// Directed bench for amo_unit with a behavioural word memory that acks after a programmable wait.
module tb_amo_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:255];
    int          ack_wait = 0;
    bit          stall_wr = 1'b0;
    int          req_seen = 0;
    int          wr_cnt = 0;
    logic [31:0] last_wr_addr = 32'd0;
    logic [31:0] last_wr_data = 32'd0;

    always #5 clk = ~clk;

    amo_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    // Memory responder: decides ack for the coming rising edge on each falling edge.
    initial begin : responder
        int wait_cnt;
        wait_cnt  = 0;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = 32'd0;
            if (rst_n && mem_req) begin
                req_seen++;
                if (!(mem_we && stall_wr) && wait_cnt >= ack_wait) begin
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        mem[mem_addr[9:2]] = mem_wdata;
                        wr_cnt++;
                        last_wr_addr = mem_addr;
                        last_wr_data = mem_wdata;
                    end else begin
                        mem_rdata = mem[mem_addr[9:2]];
                    end
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Issues one request and returns the number of cycles until rsp_valid (-1 on timeout).
    task automatic do_req(input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, output int lat);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        while (lat < 50) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) break;
        end
        if (!rsp_valid) lat = -1;
    endtask

    task automatic rsp_accept();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %0b want 1", req_ready); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %0b want 0", mem_req); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0b want 0", rsp_valid); end
        checks++;
        if ({mem_we, rsp_err, mem_addr, mem_wdata, rsp_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs we=%0b err=%0b addr=%h wdata=%h data=%h want all 0",
                     mem_we, rsp_err, mem_addr, mem_wdata, rsp_data);
        end
    endtask

    task automatic test_add();
        int lat;
        mem[8'h40] = 32'hFFFF_FFFF;
        do_req(4'd1, 32'h100, 32'd2, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL add_latency got %0d want 3", lat); end
        checks++; if (rsp_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL add_rsp_data got %h want ffffffff", rsp_data); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL add_rsp_err got %0b want 0", rsp_err); end
        checks++; if (mem[8'h40] !== 32'h0000_0001) begin errors++; $display("FAIL add_mem got %h want 00000001", mem[8'h40]); end
        checks++; if (last_wr_addr !== 32'h100) begin errors++; $display("FAIL add_wr_addr got %h want 00000100", last_wr_addr); end
        rsp_accept();
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL add_handshake ready=%0b valid=%0b want 1/0", req_ready, rsp_valid); end
    endtask

    task automatic test_minmax();
        int lat;
        int wr_before;
        mem[8'h40] = 32'h8000_0000;
        do_req(4'd5, 32'h100, 32'h0000_0001, lat);
        checks++; if (mem[8'h40] !== 32'h0000_0001) begin errors++; $display("FAIL min_mem got %h want 00000001", mem[8'h40]); end
        checks++; if (rsp_data !== 32'h8000_0000) begin errors++; $display("FAIL min_rsp_data got %h want 80000000", rsp_data); end
        rsp_accept();
        mem[8'h40] = 32'h8000_0000;
        wr_before = wr_cnt;
        do_req(4'd6, 32'h100, 32'h0000_0001, lat);
        checks++; if (wr_cnt !== wr_before + 1 || last_wr_data !== 32'h8000_0000) begin errors++; $display("FAIL max_write writes=%0d data=%h want %0d/80000000", wr_cnt - wr_before, last_wr_data, 1); end
        checks++; if (rsp_data !== 32'h8000_0000) begin errors++; $display("FAIL max_rsp_data got %h want 80000000", rsp_data); end
        rsp_accept();
    endtask

    task automatic test_lr_sc();
        int lat;
        int seen_before;
        mem[8'h80] = 32'h0000_1234;
        do_req(4'd7, 32'h200, 32'd0, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL lr_latency got %0d want 2", lat); end
        checks++; if (rsp_data !== 32'h0000_1234) begin errors++; $display("FAIL lr_rsp_data got %h want 00001234", rsp_data); end
        rsp_accept();
        do_req(4'd8, 32'h200, 32'h0000_00AA, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL sc_ok_latency got %0d want 2", lat); end
        checks++; if (rsp_data !== 32'd0) begin errors++; $display("FAIL sc_ok_rsp_data got %h want 0", rsp_data); end
        checks++; if (mem[8'h80] !== 32'h0000_00AA) begin errors++; $display("FAIL sc_ok_mem got %h want 000000aa", mem[8'h80]); end
        rsp_accept();
        seen_before = req_seen;
        do_req(4'd8, 32'h200, 32'h0000_00BB, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL sc_again_latency got %0d want 1", lat); end
        checks++; if (rsp_data !== 32'd1) begin errors++; $display("FAIL sc_again_rsp_data got %h want 1", rsp_data); end
        checks++; if (req_seen !== seen_before) begin errors++; $display("FAIL sc_again_mem_access got %0d cycles want 0", req_seen - seen_before); end
        rsp_accept();
    endtask

    task automatic test_resv_kill();
        int lat;
        mem[8'h80] = 32'h0000_0011;
        do_req(4'd7, 32'h200, 32'd0, lat);
        rsp_accept();
        do_req(4'd0, 32'h200, 32'd5, lat);
        checks++; if (rsp_data !== 32'h0000_0011) begin errors++; $display("FAIL swap_rsp_data got %h want 00000011", rsp_data); end
        rsp_accept();
        do_req(4'd8, 32'h200, 32'h0000_0099, lat);
        checks++; if (rsp_data !== 32'd1) begin errors++; $display("FAIL kill_sc_rsp_data got %h want 1", rsp_data); end
        checks++; if (mem[8'h80] !== 32'd5) begin errors++; $display("FAIL kill_sc_mem got %h want 5", mem[8'h80]); end
        rsp_accept();
        do_req(4'd7, 32'h200, 32'd0, lat);
        rsp_accept();
        do_req(4'd0, 32'h204, 32'd5, lat);
        rsp_accept();
        do_req(4'd8, 32'h200, 32'h0000_0077, lat);
        checks++; if (rsp_data !== 32'd0) begin errors++; $display("FAIL keep_sc_rsp_data got %h want 0", rsp_data); end
        checks++; if (mem[8'h80] !== 32'h0000_0077) begin errors++; $display("FAIL keep_sc_mem got %h want 00000077", mem[8'h80]); end
        rsp_accept();
    endtask

    task automatic test_errors();
        int lat;
        int seen_before;
        bit stable;
        seen_before = req_seen;
        do_req(4'hF, 32'h100, 32'd3, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL badop_latency got %0d want 1", lat); end
        checks++; if (rsp_err !== 1'b1 || rsp_data !== 32'd0) begin errors++; $display("FAIL badop_rsp err=%0b data=%h want 1/0", rsp_err, rsp_data); end
        rsp_accept();
        do_req(4'd1, 32'h102, 32'd3, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL misalign_latency got %0d want 1", lat); end
        checks++; if (rsp_err !== 1'b1 || rsp_data !== 32'd0) begin errors++; $display("FAIL misalign_rsp err=%0b data=%h want 1/0", rsp_err, rsp_data); end
        checks++; if (req_seen !== seen_before) begin errors++; $display("FAIL error_mem_access got %0d cycles want 0", req_seen - seen_before); end
        rsp_accept();
        // XOR with two wait cycles per access, then hold the response for 5 cycles.
        mem[8'h40] = 32'h0F0F_0F0F;
        ack_wait = 2;
        do_req(4'd2, 32'h100, 32'hFFFF_0000, lat);
        ack_wait = 0;
        checks++; if (lat !== 7) begin errors++; $display("FAIL xor_wait_latency got %0d want 7", lat); end
        checks++; if (mem[8'h40] !== 32'hF0F0_0F0F) begin errors++; $display("FAIL xor_mem got %h want f0f00f0f", mem[8'h40]); end
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== 32'h0F0F_0F0F || req_ready !== 1'b0) stable = 1'b0;
        end
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL hold_stable valid=%0b data=%h want 1/0f0f0f0f", rsp_valid, rsp_data); end
        rsp_accept();
    endtask

    task automatic test_reset_mid();
        int lat;
        int n;
        bit quiet;
        do_req(4'd7, 32'h200, 32'd0, lat);
        rsp_accept();
        mem[8'h40] = 32'h0000_00F0;
        stall_wr = 1'b1;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 4'd3;
        req_addr  = 32'h100;
        req_wdata = 32'h0000_0030;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (mem_we) break;
        end
        checks++; if (mem_we !== 1'b1 || mem_req !== 1'b1) begin errors++; $display("FAIL mid_reach_wr we=%0b req=%0b want 1/1", mem_we, mem_req); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL mid_busy_ready got %0b want 0", req_ready); end
        rst_n = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_drop req=%0b valid=%0b want 0/0", mem_req, rsp_valid); end
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        stall_wr = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem_req !== 1'b0) quiet = 1'b0;
        end
        checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL mid_after_release valid=%0b ready=%0b req=%0b want 0/1/0", rsp_valid, req_ready, mem_req); end
        do_req(4'd8, 32'h200, 32'h0000_0055, lat);
        checks++; if (lat !== 1 || rsp_data !== 32'd1) begin errors++; $display("FAIL mid_sc_fails lat=%0d data=%h want 1/1", lat, rsp_data); end
        rsp_accept();
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 4'd0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        test_reset();
        test_add();
        test_minmax();
        test_lr_sc();
        test_resv_kill();
        test_errors();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
